// File: rtl/cdb_arbiter.sv
// Common data bus transmit arbiter: one result buffer per FU and up to two
// round-robin broadcasts per cycle.
module cdb_arbiter #(
    parameter int unsigned       NUM_FU   = 4,
    parameter int unsigned       TAG_W    = 8,
    parameter int unsigned       DATA_W   = 64,
    parameter logic [TAG_W-1:0]  TAG_NULL = {TAG_W{1'b1}}
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       flush,
    input  logic [NUM_FU-1:0]          fu_valid_in,
    input  logic [NUM_FU*TAG_W-1:0]    fu_tag_in,
    input  logic [NUM_FU*DATA_W-1:0]   fu_value_in,
    output logic [NUM_FU-1:0]          fu_ready,
    output logic [TAG_W-1:0]           cdb1_tag_out,
    output logic [DATA_W-1:0]          cdb1_value_out,
    output logic [TAG_W-1:0]           cdb2_tag_out,
    output logic [DATA_W-1:0]          cdb2_value_out
);

    localparam int unsigned PTR_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

    logic [NUM_FU-1:0] occ_q;
    logic [TAG_W-1:0]  buf_tag_q [NUM_FU];
    logic [DATA_W-1:0] buf_val_q [NUM_FU];
    logic [PTR_W-1:0]  rr_ptr_q;

    logic              g1_vld, g2_vld;
    logic [PTR_W-1:0]  g1_idx, g2_idx, scan_idx, last_idx, rr_next;
    logic [NUM_FU-1:0] granted;
    logic [NUM_FU-1:0] accept;

    // Scan occupied buffers starting at rr_ptr; first hit -> cdb1, second -> cdb2.
    always_comb begin
        g1_vld   = 1'b0;
        g1_idx   = '0;
        g2_vld   = 1'b0;
        g2_idx   = '0;
        scan_idx = '0;
        granted  = '0;
        for (int k = 0; k < int'(NUM_FU); k++) begin
            scan_idx = PTR_W'((int'(rr_ptr_q) + k) % int'(NUM_FU));
            if (occ_q[scan_idx]) begin
                if (!g1_vld) begin
                    g1_vld = 1'b1;
                    g1_idx = scan_idx;
                end else if (!g2_vld) begin
                    g2_vld = 1'b1;
                    g2_idx = scan_idx;
                end
            end
        end
        if (g1_vld) granted[g1_idx] = 1'b1;
        if (g2_vld) granted[g2_idx] = 1'b1;
    end

    always_comb begin
        last_idx = g2_vld ? g2_idx : g1_idx;
        rr_next  = (last_idx == PTR_W'(NUM_FU - 1)) ? '0 : last_idx + 1'b1;
    end

    assign fu_ready = ~occ_q | granted;

    always_comb begin
        accept = '0;
        for (int i = 0; i < int'(NUM_FU); i++) begin
            accept[i] = fu_valid_in[i] & fu_ready[i] & ~reset & ~flush &
                        (fu_tag_in[i*TAG_W +: TAG_W] != TAG_NULL);
        end
    end

    // Reload takes priority over release so one FU can stream a result per cycle.
    always_ff @(posedge clock) begin
        if (reset || flush) begin
            occ_q    <= '0;
            rr_ptr_q <= '0;
        end else begin
            for (int i = 0; i < int'(NUM_FU); i++) begin
                if (accept[i]) begin
                    occ_q[i]     <= 1'b1;
                    buf_tag_q[i] <= fu_tag_in[i*TAG_W +: TAG_W];
                    buf_val_q[i] <= fu_value_in[i*DATA_W +: DATA_W];
                end else if (granted[i]) begin
                    occ_q[i] <= 1'b0;
                end
            end
            if (g1_vld) rr_ptr_q <= rr_next;
        end
    end

    assign cdb1_tag_out   = g1_vld ? buf_tag_q[g1_idx] : TAG_NULL;
    assign cdb1_value_out = g1_vld ? buf_val_q[g1_idx] : '0;
    assign cdb2_tag_out   = g2_vld ? buf_tag_q[g2_idx] : TAG_NULL;
    assign cdb2_value_out = g2_vld ? buf_val_q[g2_idx] : '0;

endmodule
